alu_seq: RTL and testbench

Parametrised, multicycle successor to the processor's 8-bit combinational ALU. Keeps the existing add/sub/and/or/slt encodings and adds iterative logical shifts and an optional shift-add multiplier. Uses a start/busy/done handshake. Operands are latched and results and flags are registered. Sits in the execute stage of the multicycle datapath; the control FSM holds its state while busy is high.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle between the execute-stage control and alu_seq.
// The master drives the request; the slave (the ALU) returns results, flags and status.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] ALUResultHi;
  logic             Zero;
  logic             Carry;
  logic             Overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, ALUControl, SrcA, SrcB,
    input  ALUResult, ALUResultHi, Zero, Carry, Overflow, busy, done
  );

  modport slave (
    input  start, ALUControl, SrcA, SrcB,
    output ALUResult, ALUResultHi, Zero, Carry, Overflow, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Multicycle ALU: single-cycle add/sub/and/or/slt, iterative logical shifts and, when
// ALU_MUL_EN is defined, an LSB-first shift-add multiplier. start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clock,
  input logic      reset_n,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b101;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             carry_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic             sc_ovf;
  logic             multi;
  logic [WIDTH-1:0] work_d;

  assign shamt    = bus.SrcB[SHW-1:0];
  assign add_full = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};
  assign sub_full = {1'b0, bus.SrcA} + {1'b0, ~bus.SrcB} + {{WIDTH{1'b0}}, 1'b1};
  assign work_d   = (op_q == OP_SLL) ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   hi_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     part_sum;

  // Upper half accumulates the multiplicand; the lower half holds the remaining
  // multiplier bits and fills with product bits as the pair shifts right.
  assign part_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign acc_d    = {part_sum, acc_q[WIDTH-1:1]};
`endif

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (bus.ALUControl)
      OP_ADD: begin
        sc_res   = add_full[WIDTH-1:0];
        sc_carry = add_full[WIDTH];
        sc_ovf   = (bus.SrcA[WIDTH-1] == bus.SrcB[WIDTH-1])
                && (add_full[WIDTH-1] != bus.SrcA[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = sub_full[WIDTH-1:0];
        sc_carry = sub_full[WIDTH];
        sc_ovf   = (bus.SrcA[WIDTH-1] != bus.SrcB[WIDTH-1])
                && (sub_full[WIDTH-1] != bus.SrcA[WIDTH-1]);
      end
      OP_AND:         sc_res = bus.SrcA & bus.SrcB;
      OP_OR:          sc_res = bus.SrcA | bus.SrcB;
      OP_SLT:         sc_res = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
      OP_SLL, OP_SRL: sc_res = bus.SrcA;
      default:        sc_res = '0;
    endcase
  end

  always_comb begin
    multi = ((bus.ALUControl == OP_SLL) || (bus.ALUControl == OP_SRL)) && (shamt != '0);
`ifdef ALU_MUL_EN
    if (bus.ALUControl == OP_MUL) begin
      multi = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q <= '0;
      hi_q    <= '0;
      acc_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            op_q   <= bus.ALUControl;
            if (multi) begin
              state_q <= S_EXEC;
              work_q  <= bus.SrcA;
`ifdef ALU_MUL_EN
              mcand_q <= bus.SrcA;
              acc_q   <= {{WIDTH{1'b0}}, bus.SrcB};
              cnt_q   <= (bus.ALUControl == OP_MUL) ? CW'(WIDTH) : CW'(shamt);
`else
              cnt_q   <= CW'(shamt);
`endif
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              res_q   <= sc_res;
              zero_q  <= (sc_res == '0);
              carry_q <= sc_carry;
              ovf_q   <= sc_ovf;
`ifdef ALU_MUL_EN
              hi_q    <= '0;
`endif
            end
          end
        end
        S_EXEC: begin
          cnt_q  <= cnt_q - CW'(1);
          work_q <= work_d;
`ifdef ALU_MUL_EN
          acc_q  <= acc_d;
`endif
          // Results are committed only on the final step so outputs stay frozen while busy.
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ALU_MUL_EN
            if (op_q == OP_MUL) begin
              res_q  <= acc_d[WIDTH-1:0];
              hi_q   <= acc_d[2*WIDTH-1:WIDTH];
              zero_q <= (acc_d == '0);
            end else begin
              res_q  <= work_d;
              hi_q   <= '0;
              zero_q <= (work_d == '0);
            end
`else
            res_q  <= work_d;
            zero_q <= (work_d == '0);
`endif
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ALUResult = res_q;
  assign bus.Zero      = zero_q;
  assign bus.Carry     = carry_q;
  assign bus.Overflow  = ovf_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef ALU_MUL_EN
  assign bus.ALUResultHi = hi_q;
`else
  assign bus.ALUResultHi = '0;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq (WIDTH=8): the driver pushes model results,
// an independent monitor pops and compares them on every done pulse.
module tb_alu_seq;
  localparam int W = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   tests   = 0;
  int   fails   = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         carry;
    logic         ovf;
    int           extra;
    int           done_cyc;
  } exp_t;

  exp_t sb_q[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model straight from the operation rules, using integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ua, ub, sa, sb, r, s;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    s  = ub % W;
    r  = 0;
    e.op = op; e.a = a; e.b = b;
    e.carry = 1'b0; e.ovf = 1'b0; e.extra = 0; e.hi = '0;
    case (op)
      3'b010: begin
        r = ua + ub;
        e.carry = (r >= 256);
        e.ovf   = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      3'b110: begin
        r = ua - ub;
        e.carry = (ua >= ub);
        e.ovf   = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      3'b000: r = ua & ub;
      3'b001: r = ua | ub;
      3'b111: r = (ua < ub) ? 1 : 0;
      3'b011: begin r = ua << s; e.extra = s; end
      3'b100: begin r = ua >> s; e.extra = s; end
`ifdef ALU_MUL_EN
      3'b101: begin r = ua * ub; e.hi = W'(r >> W); e.extra = W; end
`endif
      default: r = 0;
    endcase
    e.res  = W'(r);
    e.zero = (e.res == 0) && (e.hi == 0);
    e.done_cyc = 0;
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    logic [W-1:0] snap_res;
    logic [W-1:0] snap_hi;
    logic [2:0]   snap_f;
    snap_res = '0; snap_hi = '0; snap_f = '0;
    forever begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("result",       bus.ALUResult,   e.res);
          chk("result_hi",    bus.ALUResultHi, e.hi);
          chk("zero",         bus.Zero,        e.zero);
          chk("carry",        bus.Carry,       e.carry);
          chk("overflow",     bus.Overflow,    e.ovf);
          chk("done_cycle",   cyc,             e.done_cyc);
          chk("busy_at_done", bus.busy,        1);
          $display("[TB] op=%b a=%h b=%h -> res=%h hi=%h Z=%b C=%b V=%b cycle=%0d",
                   e.op, e.a, e.b, bus.ALUResult, bus.ALUResultHi,
                   bus.Zero, bus.Carry, bus.Overflow, cyc);
        end
      end else if (bus.busy) begin
        chk("hold_result", bus.ALUResult,   snap_res);
        chk("hold_hi",     bus.ALUResultHi, snap_hi);
        chk("hold_flags",  {bus.Zero, bus.Carry, bus.Overflow}, snap_f);
      end
      if (bus.done || !bus.busy) begin
        snap_res = bus.ALUResult;
        snap_hi  = bus.ALUResultHi;
        snap_f   = {bus.Zero, bus.Carry, bus.Overflow};
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (bus.busy) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy=1 expected 0 within 100 cycles");
    end
  endtask

  // Issues one operation; with hammer set, start stays high and operands churn while busy.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit hammer);
    exp_t e;
    @(negedge clock);
    wait_idle();
    e = model(op, a, b);
    e.done_cyc = cyc + 1 + e.extra;
    sb_q.push_back(e);
    bus.start      = 1'b1;
    bus.ALUControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
    @(negedge clock);
    if (hammer) begin
      for (int j = 0; j < e.extra + 1; j++) begin
        bus.SrcA       = W'($urandom);
        bus.SrcB       = W'($urandom);
        bus.ALUControl = 3'($urandom);
        @(negedge clock);
      end
    end
    bus.start = 1'b0;
    bus.SrcA  = W'($urandom);
    bus.SrcB  = W'($urandom);
  endtask

  task automatic reset_mid_op();
    @(negedge clock);
    wait_idle();
`ifdef ALU_MUL_EN
    bus.ALUControl = 3'b101;
`else
    bus.ALUControl = 3'b011;
`endif
    bus.SrcA  = 8'hFF;
    bus.SrcB  = 8'h07;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    chk("rst_busy_before", bus.busy, 1);
    @(negedge clock);
    bus.start = 1'b1;
    reset_n   = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_result",   bus.ALUResult,   0);
    chk("rst_hi",       bus.ALUResultHi, 0);
    chk("rst_zero",     bus.Zero,        0);
    chk("rst_carry",    bus.Carry,       0);
    chk("rst_overflow", bus.Overflow,    0);
    chk("rst_busy",     bus.busy,        0);
    chk("rst_done",     bus.done,        0);
    @(negedge clock);
    reset_n   = 1'b1;
    bus.start = 1'b0;
    repeat (12) @(negedge clock);
    chk("rst_idle_after", bus.busy, 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int n;
    bus.start = 1'b0; bus.ALUControl = '0; bus.SrcA = '0; bus.SrcB = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("init_result", bus.ALUResult,   0);
    chk("init_hi",     bus.ALUResultHi, 0);
    chk("init_flags",  {bus.Zero, bus.Carry, bus.Overflow}, 0);
    chk("init_status", {bus.busy, bus.done}, 0);
    reset_n = 1'b1;

    issue(3'b010, 8'hF0, 8'h20, 0);
    issue(3'b110, 8'h05, 8'h05, 0);
    issue(3'b111, 8'h03, 8'h80, 0);
    issue(3'b110, 8'h7F, 8'h80, 0);
    issue(3'b011, 8'h81, 8'h0B, 0);
    issue(3'b100, 8'hA5, 8'h08, 0);
    issue(3'b011, 8'h3C, 8'h05, 1);
    issue(3'b100, 8'hF1, 8'h07, 1);
    issue(3'b101, 8'hFF, 8'hFF, 0);
    issue(3'b001, 8'h00, 8'h00, 1);
    reset_mid_op();

    for (int i = 0; i < 200; i++) begin
      issue(3'($urandom), W'($urandom), W'($urandom), ($urandom_range(0, 4) == 0));
    end

    n = 0;
    while ((sb_q.size() != 0 || bus.busy) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("pending_at_end", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
